// File: rtl/lsu_controller_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, internal
// memory access size, fault causes, FSM states and a size-decode helper.
package lsu_controller_pkg;

  // Load access sizes as encoded in funct3
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Store access sizes share the low encodings
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Internal access size; MEM_IDLE doubles as "no legal size"
  typedef enum logic [1:0] {
    MEM_IDLE     = 2'b00,
    MEM_BYTE     = 2'b01,
    MEM_HALFWORD = 2'b10,
    MEM_WORD     = 2'b11
  } mem_size_e;

  // Fault cause encodings reported on fault_cause
  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_ERR    = 2'b11
  } lsu_state_e;

  // Map funct3 to an access size; unused encodings return MEM_IDLE
  function automatic mem_size_e decode_size(input logic [2:0] f3);
    mem_size_e sz;
    case (f3)
      FUNCT3_LB, FUNCT3_LBU: sz = MEM_BYTE;
      FUNCT3_LH, FUNCT3_LHU: sz = MEM_HALFWORD;
      FUNCT3_LW:             sz = MEM_WORD;
      default:               sz = MEM_IDLE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_controller_align.sv
// Combinational lane steering: legality/alignment checks, byte enables,
// store data replication and load lane extraction with sign/zero extension.
module lsu_controller_align
  import lsu_controller_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic        legal,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  mem_size_e   size;
  logic        zero_ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Decode size, check alignment, steer lanes in both directions
  always_comb begin
    size        = decode_size(funct3);
    zero_ext    = funct3[2];
    legal       = (size != MEM_IDLE);
    aligned     = 1'b1;
    be          = 4'b0000;
    wdata_lanes = 32'h0;
    rdata_ext   = 32'h0;

    case (byte_off)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size)
      MEM_BYTE: begin
        be          = 4'b0001 << byte_off;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = zero_ext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      MEM_HALFWORD: begin
        aligned     = ~byte_off[0];
        be          = 4'b0011 << {byte_off[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = zero_ext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      MEM_WORD: begin
        aligned     = (byte_off == 2'b00);
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = mem_rdata;
      end
      default: begin
        aligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: accepts one load or store from decode, runs a
// req/ack handshake with data memory, and returns an extended load result or
// a fault (misaligned, illegal size, timeout).
//
// Memory handshake: mem_req rises in the first ACCESS cycle and stays high,
// with mem_we/mem_addr/mem_be/mem_wdata stable, until the cycle mem_ack is
// sampled high; that cycle completes the transfer and mem_rdata is captured.
// mem_ack outside ACCESS carries no meaning and is ignored.
module lsu_controller
  import lsu_controller_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [31:0]           rdata_q;
  logic [1:0]            cause_q;

  logic        start_any;
  logic        in_idle;
  logic        in_access;
  logic        timed_out;
  logic [2:0]  chk_funct3;
  logic [1:0]  chk_off;
  logic        legal;
  logic        aligned;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;

  assign start_any = start_load | start_store;
  assign in_idle   = (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);
  assign timed_out = in_access & ~mem_ack & (cnt_q == CNT_LAST);

  // In IDLE the checker looks at the incoming request; afterwards at the latched one
  assign chk_funct3 = in_idle ? funct3    : funct3_q;
  assign chk_off    = in_idle ? addr[1:0] : addr_q[1:0];

  lsu_controller_align u_align (
    .funct3      (chk_funct3),
    .byte_off    (chk_off),
    .wdata       (wdata_q),
    .mem_rdata   (mem_rdata),
    .legal       (legal),
    .aligned     (aligned),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; illegal size takes precedence over misalignment
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_any) state_next = (legal && aligned) ? ST_ACCESS : ST_ERR;
      end
      ST_ACCESS: begin
        if (mem_ack)        state_next = ST_DONE;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter, load result and fault cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      cause_q  <= CAUSE_NONE;
    end else begin
      if (in_idle && start_any) begin
        addr_q   <= addr;
        funct3_q <= funct3;
        wdata_q  <= wdata;
        we_q     <= start_store;
        if (!legal)        cause_q <= CAUSE_ILLEGAL;
        else if (!aligned) cause_q <= CAUSE_MISALIGNED;
      end
      if (in_access) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (mem_ack && !we_q) rdata_q <= rdata_ext;
        if (timed_out)        cause_q <= CAUSE_TIMEOUT;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Outputs decoded from state; memory bus is zero outside ACCESS
  always_comb begin
    stall       = (in_idle & start_any) | in_access;
    done        = (state == ST_DONE);
    fault       = (state == ST_ERR);
    rdata       = rdata_q;
    fault_cause = cause_q;
    mem_req     = in_access;
    mem_we      = in_access & we_q;
    mem_addr    = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_be      = in_access ? be : 4'b0000;
    mem_wdata   = in_access ? wdata_lanes : 32'h0;
  end

endmodule
